// File: rtl/register_file.sv
// Y86-64 program register file: 15 x 64-bit registers, two write-back ports (E, M),
// two decode read ports, a debug read port and a saturating commit counter.
module register_file #(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA,
  output logic [63:0] valB,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val,
  output logic [31:0] wr_count
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [63:0] regs_q [15];
  logic [3:0]  rd_sel [2];
  logic [63:0] rd_val [2];
  logic        we_e, we_m;

  assign we_e = wb_en && (dstE != RNONE);
  assign we_m = wb_en && (dstM != RNONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == int'(RSP)) ? RSP_INIT : 64'h0;
      end
      wr_count <= 32'h0;
    end else begin
      if (we_e) regs_q[dstE] <= valE;
      // M is written after E so it wins when both target the same register
      if (we_m) regs_q[dstM] <= valM;
      if ((we_e || we_m) && (wr_count != 32'hFFFF_FFFF)) wr_count <= wr_count + 32'd1;
    end
  end

  assign rd_sel[0] = srcA;
  assign rd_sel[1] = srcB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = 64'h0;
      if (rd_sel[p] != RNONE) begin
        rd_val[p] = regs_q[rd_sel[p]];
        if (BYPASS) begin
          if (we_m && (rd_sel[p] == dstM))      rd_val[p] = valM;
          else if (we_e && (rd_sel[p] == dstE)) rd_val[p] = valE;
        end
      end
    end
    dbg_val = (dbg_sel != RNONE) ? regs_q[dbg_sel] : 64'h0;
  end

  assign valA = rd_val[0];
  assign valB = rd_val[1];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench: one non-bypassed and one bypassed register_file
// share the same stimulus; both start with %rsp = 64'h200.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n, wb_en;
  logic [3:0]  dstE, dstM, srcA, srcB, dbg_sel;
  logic [63:0] valE, valM;
  logic [63:0] valA0, valB0, dbg0, valA1, valB1, dbg1;
  logic [31:0] cnt0, cnt1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_file #(.RSP_INIT(64'h200), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .dstE(dstE), .valE(valE), .dstM(dstM),
    .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
    .dbg_sel(dbg_sel), .dbg_val(dbg0), .wr_count(cnt0)
  );

  register_file #(.RSP_INIT(64'h200), .BYPASS(1'b1)) u_by (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .dstE(dstE), .valE(valE), .dstM(dstM),
    .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
    .dbg_sel(dbg_sel), .dbg_val(dbg1), .wr_count(cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
  endtask

  initial begin
    rst_n = 1'b0; srcA = 4'hF; srcB = 4'hF; dbg_sel = 4'h0;
    idle();
    edge_step();
    edge_step();
    rst_n = 1'b1;

    // Reset state
    srcA = 4'd4; srcB = 4'd0; dbg_sel = 4'd4;
    #1;
    check("rst_valA_rsp", valA0, 64'h200);
    check("rst_valB_r0", valB0, 64'h0);
    check("rst_count", {32'h0, cnt0}, 64'h0);
    check("rst_byp_valA_rsp", valA1, 64'h200);
    check("rst_dbg_rsp", dbg0, 64'h200);

    // Single write on E port
    wb_en = 1'b1; dstE = 4'd3; valE = 64'hDEAD; dstM = 4'hF; srcA = 4'd3;
    #1;
    check("single_pre_nobyp", valA0, 64'h0);
    check("single_pre_byp", valA1, 64'hDEAD);
    edge_step();
    idle();
    #1;
    check("single_post", valA0, 64'hDEAD);
    check("single_count", {32'h0, cnt0}, 64'd1);
    check("single_count_byp", {32'h0, cnt1}, 64'd1);

    // E/M conflict on %rsp: M wins
    wb_en = 1'b1; dstE = 4'd4; valE = 64'h1F8; dstM = 4'd4; valM = 64'hAA; srcA = 4'd4;
    #1;
    check("conflict_pre_nobyp", valA0, 64'h200);
    check("conflict_pre_byp_m", valA1, 64'hAA);
    edge_step();
    idle();
    dbg_sel = 4'd4;
    #1;
    check("conflict_post", valA0, 64'hAA);
    check("conflict_dbg", dbg0, 64'hAA);
    check("conflict_count", {32'h0, cnt0}, 64'd2);

    // Stall: nothing commits, bypass gated off
    wb_en = 1'b0; dstE = 4'd2; valE = 64'd5; srcA = 4'd2;
    #1;
    check("stall_pre_byp", valA1, 64'h0);
    edge_step();
    idle();
    #1;
    check("stall_reg2", valA0, 64'h0);
    check("stall_count", {32'h0, cnt0}, 64'd2);

    // Both destinations RNONE
    wb_en = 1'b1; dstE = 4'hF; valE = 64'h77; dstM = 4'hF; valM = 64'h88;
    srcA = 4'hF; srcB = 4'd3;
    #1;
    check("rnone_valA", valA0, 64'h0);
    check("rnone_valA_byp", valA1, 64'h0);
    edge_step();
    idle();
    #1;
    check("rnone_count", {32'h0, cnt0}, 64'd2);
    check("rnone_reg3", valB0, 64'hDEAD);

    // Two distinct destinations in one edge count once
    wb_en = 1'b1; dstE = 4'd6; valE = 64'h66; dstM = 4'd7; valM = 64'h77;
    srcA = 4'd6; srcB = 4'd7;
    #1;
    check("dual_pre_byp_a", valA1, 64'h66);
    check("dual_pre_byp_b", valB1, 64'h77);
    edge_step();
    idle();
    #1;
    check("dual_reg6", valA0, 64'h66);
    check("dual_reg7", valB0, 64'h77);
    check("dual_count", {32'h0, cnt0}, 64'd3);

    // Bypass: reg5 = 7, then write 9 and read in the same cycle
    wb_en = 1'b1; dstE = 4'd5; valE = 64'd7;
    edge_step();
    dstE = 4'd5; valE = 64'd9; srcA = 4'd5; dbg_sel = 4'd5;
    #1;
    check("byp_valA_same_cycle", valA1, 64'd9);
    check("byp_nobyp_valA_old", valA0, 64'd7);
    check("byp_dbg_before", dbg1, 64'd7);
    edge_step();
    idle();
    #1;
    check("byp_dbg_after", dbg1, 64'd9);
    check("byp_valA_after", valA1, 64'd9);
    check("byp_count", {32'h0, cnt1}, 64'd5);

    // Reset has priority over a concurrent write
    rst_n = 1'b0; wb_en = 1'b1; dstE = 4'd1; valE = 64'h55;
    edge_step();
    rst_n = 1'b1;
    idle();
    srcA = 4'd1; srcB = 4'd4; dbg_sel = 4'd5;
    #1;
    check("rstwr_reg1", valA0, 64'h0);
    check("rstwr_reg1_byp", valA1, 64'h0);
    check("rstwr_count", {32'h0, cnt0}, 64'h0);
    check("rstwr_rsp", valB0, 64'h200);
    check("rstwr_reg5", dbg0, 64'h0);
    dbg_sel = 4'hF;
    #1;
    check("dbg_rnone", dbg0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
